// File: rtl/uart_pkg.sv
// Shared UART definitions: serializer state encoding, baud divider helper
// and the line idle level used by both the transmit and receive sides.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam logic IDLE_LEVEL = 1'b1;

    // Clock cycles per bit, integer-truncated
    function automatic int unsigned baud_div(input int unsigned clk_mhz,
                                             input int unsigned baud);
        return (clk_mhz * 32'd1000000) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous first-word-fall-through FIFO for the UART transmit path.
// rd_data always shows the oldest entry while empty is low.
module uart_tx_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_AW    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [FIFO_AW:0]      level
);

    localparam int unsigned DEPTH = 2 ** FIFO_AW;
    localparam int unsigned PTR_W = FIFO_AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic                  do_wr;
    logic                  do_rd;

    // Status from the wrap-bit pointers; nothing here depends on this cycle's pop
    always_comb begin
        full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
        empty = (wr_ptr_q == rd_ptr_q);
        level = wr_ptr_q - rd_ptr_q;
        rd_data = mem[rd_ptr_q[FIFO_AW-1:0]];
    end

    // Gated handshakes and next pointer values
    always_comb begin
        do_wr    = wr_en && !full;
        do_rd    = rd_en && !empty;
        wr_ptr_d = do_wr ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    end

    // Pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array, no reset needed: contents are qualified by the pointers
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q[FIFO_AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_write.sv
// UART transmitter: valid/ready byte intake into a FIFO, then 8N1
// serialization onto a registered tx line with a one-cycle tx_done pulse.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_write
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned FIFO_AW      = 4,
    parameter int unsigned BAUDRATE     = 9600,
    parameter int unsigned CLK_FREQ_MHZ = 125
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  valid_in,
    output logic                  ready_in,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_done,
    output logic [FIFO_AW:0]      fifo_level
);

    localparam int unsigned BAUD_DIV = baud_div(CLK_FREQ_MHZ, BAUDRATE);
    localparam int unsigned CNT_W    = $clog2(BAUD_DIV);
    localparam int unsigned BIT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    tx_state_e             state_q, state_d;
    logic [CNT_W-1:0]      baud_cnt_q, baud_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  tx_q, tx_d;
    logic                  tx_busy_q, tx_busy_d;
    logic                  tx_done_q, tx_done_d;
`ifdef UART_TX_PARITY_EN
    logic                  parity_q, parity_d;
`endif

    logic                  pop_c;
    logic                  push_c;
    logic                  baud_last_c;
    logic                  bit_last_c;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_full;
    logic                  fifo_empty;

    // Byte buffer between the producer and the serializer
    uart_tx_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_AW    (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push_c),
        .rd_en   (pop_c),
        .wr_data (tx_data),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // Intake handshake; ready only looks at the registered full flag
    always_comb begin
        ready_in = !fifo_full;
        push_c   = valid_in && !fifo_full;
    end

    // Bit-boundary and last-data-bit decodes
    always_comb begin
        baud_last_c = (baud_cnt_q == CNT_W'(BAUD_DIV - 1));
        bit_last_c  = (bit_cnt_q == BIT_W'(DATA_WIDTH - 1));
    end

    // Serializer next state; tx is computed from the current state and registered
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_d       = IDLE_LEVEL;
        tx_done_d  = 1'b0;
        pop_c      = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif

        if (state_q != IDLE) begin
            baud_cnt_d = baud_last_c ? '0 : baud_cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop_c      = 1'b1;
                    shift_d    = fifo_rd_data;
                    baud_cnt_d = '0;
                    state_d    = START;
`ifdef UART_TX_PARITY_EN
                    parity_d   = ^fifo_rd_data;
`endif
                end
            end
            START: begin
                tx_d = 1'b0;
                if (baud_last_c) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                tx_d = shift_q[0];
                if (baud_last_c) begin
                    shift_d = shift_q >> 1;
                    if (bit_last_c) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx_d = parity_q;
                if (baud_last_c) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                tx_d = IDLE_LEVEL;
                if (baud_last_c) begin
                    tx_done_d = 1'b1;
                    if (!fifo_empty) begin
                        pop_c   = 1'b1;
                        shift_d = fifo_rd_data;
                        state_d = START;
`ifdef UART_TX_PARITY_EN
                        parity_d = ^fifo_rd_data;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        tx_busy_d = (state_d != IDLE);
    end

    // Serializer registers; reset aborts any frame in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx_q       <= IDLE_LEVEL;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            tx_busy_q  <= tx_busy_d;
            tx_done_q  <= tx_done_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    // Output drive
    always_comb begin
        tx      = tx_q;
        tx_busy = tx_busy_q;
        tx_done = tx_done_q;
    end

endmodule

// File: tb/tb_uart_tx_write.sv
// Directed self-checking bench for uart_tx_write at BAUD_DIV = 10.
module tb_uart_tx_write;

    localparam int BD = 10;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * BD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       valid_in = 1'b0;
    logic       ready_in;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;
    logic [4:0] fifo_level;

    int checks = 0;
    int errors = 0;

    uart_tx_write #(
        .DATA_WIDTH   (8),
        .FIFO_AW      (4),
        .BAUDRATE     (100000),
        .CLK_FREQ_MHZ (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .valid_in   (valid_in),
        .ready_in   (ready_in),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    function automatic logic exp_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
        if (idx == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        valid_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Called on frame cycle 0 (first cycle tx is low); ends on frame cycle FRAME_CYC-1
    task automatic check_frame(input logic [7:0] b, input string tag);
        logic exp_tx;
        for (int cyc = 0; cyc < FRAME_CYC; cyc++) begin
            if (cyc > 0) @(negedge clk);
            exp_tx = exp_bit(b, cyc / BD);
            checks++;
            if (tx !== exp_tx) begin
                errors++;
                $display("FAIL %s_tx cyc=%0d got=%b expected=%b", tag, cyc, tx, exp_tx);
            end
            checks++;
            if (tx_done !== (cyc == FRAME_CYC - 1)) begin
                errors++;
                $display("FAIL %s_done cyc=%0d got=%b expected=%b", tag, cyc, tx_done, (cyc == FRAME_CYC - 1));
            end
        end
    endtask

    // Line decoder sampling near the middle of each bit
    task automatic rx_byte(output logic [7:0] b);
        int n;
        n = 0;
        b = 8'h00;
        while (tx !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (tx !== 1'b0) begin
            errors++;
            $display("FAIL rx_start_timeout got=%b expected=0", tx);
        end
        repeat (4) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            repeat (BD) @(negedge clk);
            b[k] = tx;
        end
`ifdef UART_TX_PARITY_EN
        repeat (BD) @(negedge clk);
        checks++;
        if (tx !== ^b) begin
            errors++;
            $display("FAIL rx_parity got=%b expected=%b", tx, ^b);
        end
`endif
        repeat (BD) @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL rx_stop got=%b expected=1", tx);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({tx, ready_in, tx_busy, tx_done} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_outputs got tx/rdy/busy/done=%b expected=1100", {tx, ready_in, tx_busy, tx_done});
        end
        checks++;
        if (fifo_level !== 5'd0) begin
            errors++;
            $display("FAIL reset_level got=%0d expected=0", fifo_level);
        end
    endtask

    task automatic test_single();
        do_reset();
        tx_data = 8'hA5;
        valid_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
        checks++;
        if ({tx, tx_busy, fifo_level} !== {1'b1, 1'b0, 5'd1}) begin
            errors++;
            $display("FAIL single_push got tx=%b busy=%b lvl=%0d expected tx=1 busy=0 lvl=1", tx, tx_busy, fifo_level);
        end
        @(negedge clk);
        checks++;
        if ({tx, tx_busy, fifo_level} !== {1'b1, 1'b1, 5'd0}) begin
            errors++;
            $display("FAIL single_pop got tx=%b busy=%b lvl=%0d expected tx=1 busy=1 lvl=0", tx, tx_busy, fifo_level);
        end
        @(negedge clk);
        check_frame(8'hA5, "single");
        checks++;
        if (tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL single_busy_end got=%b expected=0", tx_busy);
        end
        @(negedge clk);
        checks++;
        if ({tx, tx_done} !== 2'b10) begin
            errors++;
            $display("FAIL single_after got tx/done=%b expected=10", {tx, tx_done});
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        tx_data = 8'h00;
        valid_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_data = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        valid_in = 1'b0;
        @(negedge clk);
        check_frame(8'h00, "b2b0");
        @(negedge clk);
        check_frame(8'hFF, "b2b1");
        @(negedge clk);
        checks++;
        if ({tx, tx_busy, tx_done} !== 3'b100) begin
            errors++;
            $display("FAIL b2b_end got tx/busy/done=%b expected=100", {tx, tx_busy, tx_done});
        end
    endtask

    task automatic test_fill();
        int acc;
        logic [7:0] got;
        do_reset();
        acc = 0;
        fork
            begin
                logic take;
                for (int cyc = 0; cyc < 40; cyc++) begin
                    valid_in = (acc < 20);
                    tx_data  = 8'h40 + 8'(acc);
                    take     = valid_in && ready_in;
                    @(posedge clk);
                    if (take) acc++;
                    @(negedge clk);
                end
                valid_in = 1'b0;
                checks++;
                if (acc != 17) begin
                    errors++;
                    $display("FAIL fill_accepted got=%0d expected=17", acc);
                end
                checks++;
                if ({ready_in, fifo_level} !== {1'b0, 5'd16}) begin
                    errors++;
                    $display("FAIL fill_full got rdy=%b lvl=%0d expected rdy=0 lvl=16", ready_in, fifo_level);
                end
            end
            begin
                for (int k = 0; k < 17; k++) begin
                    rx_byte(got);
                    checks++;
                    if (got !== 8'h40 + 8'(k)) begin
                        errors++;
                        $display("FAIL fill_order idx=%0d got=%h expected=%h", k, got, 8'h40 + 8'(k));
                    end
                end
            end
        join
        repeat (10) @(negedge clk);
        checks++;
        if ({tx_busy, fifo_level} !== {1'b0, 5'd0}) begin
            errors++;
            $display("FAIL fill_drained got busy=%b lvl=%0d expected busy=0 lvl=0", tx_busy, fifo_level);
        end
        begin
            bit low_seen;
            low_seen = 1'b0;
            repeat (150) begin
                @(negedge clk);
                if (tx !== 1'b1) low_seen = 1'b1;
            end
            checks++;
            if (low_seen) begin
                errors++;
                $display("FAIL fill_extra_frame got=1 expected=0");
            end
        end
    endtask

    task automatic test_full_pop();
        int n;
        do_reset();
        tx_data = 8'h5A;
        valid_in = 1'b1;
        n = 0;
        while (fifo_level !== 5'd16 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ({ready_in, fifo_level} !== {1'b0, 5'd16}) begin
            errors++;
            $display("FAIL fullpop_fill got rdy=%b lvl=%0d expected rdy=0 lvl=16", ready_in, fifo_level);
        end
        n = 0;
        while (fifo_level === 5'd16 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ({ready_in, tx_done, fifo_level} !== {1'b1, 1'b1, 5'd15}) begin
            errors++;
            $display("FAIL fullpop_refused got rdy=%b done=%b lvl=%0d expected rdy=1 done=1 lvl=15", ready_in, tx_done, fifo_level);
        end
        @(negedge clk);
        checks++;
        if ({ready_in, fifo_level} !== {1'b0, 5'd16}) begin
            errors++;
            $display("FAIL fullpop_refill got rdy=%b lvl=%0d expected rdy=0 lvl=16", ready_in, fifo_level);
        end
        valid_in = 1'b0;
    endtask

    task automatic test_mid_reset();
        logic [7:0] q [4];
        bit bad;
        q[0] = 8'h11; q[1] = 8'h22; q[2] = 8'h33; q[3] = 8'h44;
        do_reset();
        tx_data = 8'h3C;
        valid_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            tx_data = q[i];
            @(posedge clk);
            @(negedge clk);
        end
        valid_in = 1'b0;
        checks++;
        if (fifo_level !== 5'd4) begin
            errors++;
            $display("FAIL midrst_level got=%0d expected=4", fifo_level);
        end
        // now at frame cycle 2; advance to the middle of data bit 3
        repeat (43) @(negedge clk);
        checks++;
        if ({tx, tx_busy} !== 2'b11) begin
            errors++;
            $display("FAIL midrst_bit3 got tx/busy=%b expected=11", {tx, tx_busy});
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({tx, ready_in, tx_busy, tx_done, fifo_level} !== {4'b1100, 5'd0}) begin
            errors++;
            $display("FAIL midrst_after got tx/rdy/busy/done=%b lvl=%0d expected 1100 lvl=0", {tx, ready_in, tx_busy, tx_done}, fifo_level);
        end
        bad = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_done !== 1'b0 || tx_busy !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL midrst_quiet got activity=1 expected=0");
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] v [2];
        v[0] = 8'h07; v[1] = 8'h03;
        for (int i = 0; i < 2; i++) begin
            do_reset();
            tx_data = v[i];
            valid_in = 1'b1;
            @(posedge clk);
            @(negedge clk);
            valid_in = 1'b0;
            @(negedge clk);
            @(negedge clk);
            check_frame(v[i], "parity");
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fill();
        test_full_pop();
        test_mid_reset();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_write.md
Name: uart_tx_write

Overview:
- Transmit-side counterpart of the receive path: accepts bytes from a local producer over a valid/ready handshake and buffers them in an internal FIFO.
- Serializes each byte onto the UART tx line as 8N1: start bit, DATA_WIDTH data bits LSB-first, one stop bit.
- Raises a one-cycle tx_done pulse per completed frame, usable as an interrupt.
- Sits between the bus-side write logic and the tx pad.

Parameters:
- DATA_WIDTH, 8, bits per character.
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW (16).
- BAUDRATE, 9600, line rate in bit/s.
- CLK_FREQ_MHZ, 125, clk frequency in MHz. BAUD_DIV = CLK_FREQ_MHZ*1000000/BAUDRATE, integer-truncated (13020 at defaults); must be >= 2.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- tx_data  in  DATA_WIDTH  byte to send.
- valid_in  in  1  tx_data valid.
- ready_in  out  1  block can accept a byte; = ~full.
- tx  out  1  serial line, idle high.
- tx_busy  out  1  a frame is on the line (state != IDLE).
- tx_done  out  1  one-cycle pulse at the end of each stop bit.
- fifo_level  out  FIFO_AW+1  number of bytes queued, excluding the byte currently being shifted.

Behaviour:
- Clock and reset: one clock (clk). Reset rst is synchronous and active-high; it is sampled only on the clk rising edge.
- Reset values: tx=1, ready_in=1, tx_busy=0, tx_done=0, fifo_level=0. FIFO pointers cleared; FSM=IDLE; baud counter and bit counter = 0.
- Reset mid-frame aborts the frame. tx returns high the cycle after the reset edge, and queued bytes are discarded.
- Push: a byte is written when valid_in && ready_in at the clk edge. When full, ready_in=0 and the write is ignored, even if a pop happens in the same cycle; ready_in is never combinationally dependent on pop.
- Pop: occurs when FSM is in IDLE (or at the last cycle of STOP) and the FIFO is not empty. Pop and push in the same cycle leave fifo_level unchanged. A pop is never issued when empty.
- Push into an empty FIFO: the data is visible to the FSM the next cycle, so first tx falling edge = push edge + 2 cycles.
- FIFO pointers are FIFO_AW+1 bits with wrap-around. full = MSBs differ and the rest are equal; empty = pointers equal.
- FSM states and transitions:
  - IDLE: tx=1. If not empty, pop, load the shift register, clear the baud counter, go to START.
  - START: tx=0 for BAUD_DIV cycles, then go to DATA with bit_cnt=0.
  - DATA: tx = shift_reg[0] for BAUD_DIV cycles per bit, then shift right. After bit DATA_WIDTH-1, go to STOP.
  - STOP: tx=1 for BAUD_DIV cycles. On the last cycle, tx_done=1 (registered, visible the next cycle for exactly 1 cycle). If not empty, pop and go to START with no idle gap; otherwise go to IDLE.
- Frame length: exactly (DATA_WIDTH+2)*BAUD_DIV cycles. Back-to-back frames have no gap cycles.
- Baud counter runs 0..BAUD_DIV-1 and wraps to 0 at each bit boundary. Width = clog2(BAUD_DIV).
- tx is driven from a register (glitch-free).

Optional Feature:
- UART_TX_PARITY_EN defined: a PARITY state is inserted between DATA and STOP. It drives the even-parity bit (XOR of the data bits) for BAUD_DIV cycles, and the frame becomes (DATA_WIDTH+3)*BAUD_DIV cycles.
- Undefined: no PARITY state, plain 8N1, and no parity logic is synthesized.

Decomposition:
- Package uart_pkg holds:
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP);
  - a function baud_div(clk_mhz, baud);
  - the IDLE_LEVEL=1'b1 constant, shared with the receive side.
- Sub-module uart_tx_fifo: synchronous FIFO with wr_en/rd_en/wr_data/rd_data/full/empty/level. It uses first-word fall-through so rd_data is valid whenever empty=0.
- Serializer FSM stays in the top.

Test Plan (CLK_FREQ_MHZ=1, BAUDRATE=100000 -> BAUD_DIV=10):
- Reset then push 0xA5 once -> tx falls 2 cycles after the push. Line reads 0,1,0,1,0,0,1,0,1,1 (each 10 cycles). tx_done pulses once at cycle 100 of the frame; tx_busy=0 afterwards.
- Push 0x00, 0xFF back-to-back -> two frames totalling 200 cycles, no idle cycle between them, two tx_done pulses exactly 100 cycles apart.
- Hold valid_in high with 20 bytes while the line is busy -> ready_in drops when fifo_level=16. Exactly 17 bytes are accepted (16 queued + 1 in flight), and all are transmitted in order.
- Full FIFO, valid_in=1 in the same cycle a pop occurs -> push refused, fifo_level goes 16->15, ready_in=1 the next cycle.
- Assert rst at bit 3 of 0x3C with 4 bytes queued -> tx=1 the next cycle, fifo_level=0, no tx_done, nothing transmitted afterwards.
- With UART_TX_PARITY_EN, send 0x07 -> parity bit = 1, frame = 110 cycles; send 0x03 -> parity bit = 0.
